dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Load/store initiator sitting between the CPU MEM stage and the word-wide data memory. It accepts one byte/halfword/word load or store request at a time and sequences the memory interface: address and data setup, then a single write strobe pulse. It performs read-modify-write for sub-word stores and lane extraction with sign/zero extension for loads. Misaligned or reserved-size requests are flagged without touching memory.

## Interface
- ADDR_W, 10, word-address width driven to data memory
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&&ready at clk edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores/errors
- rsp_err  out  1  misaligned or reserved size, valid with rsp_valid
- dm_address  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- dm_dmwr  out  1  write strobe; memory writes on its rising edge
- dm_din  out  32  write data to memory
- dm_dout  in  32  combinational read data from memory

## Operation
- States: IDLE, RD, WSET, WPULSE, RSP. req_ready = (state==IDLE).
- Accept in IDLE: register addr, size, we, signed, wdata; drive dm_address from registered address.
- Error check at accept: size 11, half with addr[0]=1, word with addr[1:0]!=0 -> RSP with rsp_err=1; no memory access, dm_dmwr stays 0.
- Load: IDLE -> RD -> RSP. In RD, capture dm_dout; extract lane (little-endian, byte n = bits [8n+7:8n], half n = bits [16n+15:16n]); sign- or zero-extend per req_signed (word ignores it).
- Word store: IDLE -> WSET -> WPULSE -> RSP. dm_din = wdata.
- Sub-word store: IDLE -> RD -> WSET -> WPULSE -> RSP. In RD capture word; WSET drives dm_din = captured word with the addressed lane replaced by wdata low bits.
- dm_dmwr = 1 only in WPULSE, registered, glitch-free; exactly one rising edge per store.
- RSP: rsp_valid=1 for one cycle, then IDLE. No response backpressure.
- req_valid during busy states ignored (not accepted).

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, dm_address 0, dm_dmwr 0, dm_din 0.
- Accept edge = k. rsp_valid high during cycle after edge: error k; load k+1; word store k+2; sub-word store k+3.
- Next request accepted at the edge following the RSP cycle (back-to-back throughput: load 3 cycles, word store 4, sub-word store 5).
- dm_address stable from edge k through RSP; dm_din stable one full cycle (WSET) before dm_dmwr rises and throughout WPULSE.
- Reset asserted mid-operation: immediate return to IDLE, dm_dmwr forced 0, no response issued. If asserted before WPULSE, memory unmodified.
- Back-to-back store then load to same word: load returns the stored value.

## Structure
- Shared package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, ADDR_W default.
- One combinational sub-module lane_align: inputs word, byte offset, size, signed, store data; outputs extracted load value and merged store word. FSM and registers stay in dm_access_ctrl.

## Test plan
- Reset, then word load at 0x14 against DM preloaded dmem[i]=i -> rsp_valid at k+1, rsp_rdata 0x00000005, rsp_err 0.
- Word store 0xDEADBEEF to 0x08, then lb 0x0B -> 0xFFFFFFDE; lbu 0x0B -> 0x000000DE; lh 0x0A -> 0xFFFFDEAD; lhu 0x08 -> 0x0000BEEF.
- sb 0x55 to 0x09 after above -> one dm_dmwr pulse, dm_din 0xDEAD55EF; word load 0x08 returns 0xDEAD55EF; rsp at k+3.
- lh at 0x03 and sw at 0x06 and size 11 -> rsp_err 1 at k, rsp_rdata 0, dm_dmwr never rises.
- req_valid held high continuously with alternating sw/lw -> each accepted only in IDLE, one response per request, no lost or duplicated strobes.
- rst_n low during WSET of sw 0x12345678 to 0x10 -> dm_dmwr stays 0, no rsp_valid, later load 0x10 returns 0x00000004.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// FSM state type and the default word-address width.
package mem_pkg;

   localparam int ADDR_W_DEF = 10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WSET,
      ST_WPULSE,
      ST_RSP
   } state_t;

   // A request is rejected for a reserved size or a lane that crosses its natural alignment.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane for read-modify-write.
module lane_align
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_word[{i_offset, 3'b000} +: 8];
      w_half   = i_word[{i_offset[1], 4'b0000} +: 16];
      o_load   = i_word;
      o_merged = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            o_merged = i_word;
            o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_load = {{16{i_signed & w_half[15]}}, w_half};
            o_merged = i_word;
            o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
         end
         default: begin
            o_load   = i_word;
            o_merged = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store initiator between the MEM stage and word-wide data memory:
// one request at a time, read-modify-write for sub-word stores, single write pulse.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready; accept request, register fields, flag errors
//   ST_RD     | address on memory; sample read word (load result / RMW)
//   ST_WSET   | dm_din set up one full cycle before the strobe
//   ST_WPULSE | dm_dmwr high; memory writes on its rising edge
//   ST_RSP    | one-cycle rsp_valid, then back to idle
module dm_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] dm_address,
   output logic              dm_dmwr,
   output logic [31:0]       dm_din,
   input  logic [31:0]       dm_dout
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W+1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_we;
   logic              r_signed;
   logic [31:0]       r_wdata;
   logic [31:0]       r_din;
   logic              r_dmwr;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_accept;
   logic              w_req_bad;
   logic [31:0]       w_load;
   logic [31:0]       w_merged;
   logic [31:0]       w_din_nxt;
   logic              w_dmwr_nxt;
   logic              w_rsp_valid_nxt;
   logic [31:0]       w_rsp_rdata_nxt;
   logic              w_rsp_err_nxt;

   assign w_accept  = (r_state == ST_IDLE) && req_valid;
   assign w_req_bad = req_bad(req_size, req_addr[1:0]);

   lane_align u_lane_align (
      .i_word   (dm_dout),
      .i_offset (r_addr[1:0]),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_req_bad)                          w_state_nxt = ST_RSP;
               else if (req_we && req_size == SZ_WORD) w_state_nxt = ST_WSET;
               else                                    w_state_nxt = ST_RD;
            end
         end
         ST_RD:     w_state_nxt = r_we ? ST_WSET : ST_RSP;
         ST_WSET:   w_state_nxt = ST_WPULSE;
         ST_WPULSE: w_state_nxt = ST_RSP;
         ST_RSP:    w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Output-register next values; only the error path jumps from idle straight to RSP.
   always_comb begin
      w_dmwr_nxt      = (w_state_nxt == ST_WPULSE);
      w_rsp_valid_nxt = (w_state_nxt == ST_RSP);
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_din_nxt       = r_din;
      if (w_state_nxt == ST_RSP && r_state != ST_RSP) begin
         w_rsp_rdata_nxt = (r_state == ST_RD && !r_we) ? w_load : 32'h0;
         w_rsp_err_nxt   = (r_state == ST_IDLE);
      end
      if (w_accept && req_we && req_size == SZ_WORD && !w_req_bad)
         w_din_nxt = req_wdata;
      else if (r_state == ST_RD && r_we)
         w_din_nxt = w_merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_size      <= SZ_BYTE;
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_wdata     <= 32'h0;
         r_din       <= 32'h0;
         r_dmwr      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr   <= req_addr[ADDR_W+1:0];
            r_size   <= req_size;
            r_we     <= req_we;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
         end
         r_din       <= w_din_nxt;
         r_dmwr      <= w_dmwr_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_err    = r_rsp_err;
   assign dm_address = r_addr[ADDR_W+1:2];
   assign dm_dmwr    = r_dmwr;
   assign dm_din     = r_din;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: stimulus pushes expected responses and
// writes into queues; monitors pop and compare when the DUT responds or strobes.
module tb_dm_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [9:0]  dm_address;
   logic        dm_dmwr;
   logic [31:0] dm_din;
   logic [31:0] dm_dout;

   dm_access_ctrl #(.ADDR_W(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .dm_address (dm_address),
      .dm_dmwr    (dm_dmwr),
      .dm_din     (dm_din),
      .dm_dout    (dm_dout)
   );

   always #5 clk = ~clk;

   logic [31:0] dmem [1024];
   assign dm_dout = dmem[dm_address];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_t;

   rsp_t        rq[$];
   logic [31:0] wq_din[$];
   logic [9:0]  wq_adr[$];
   rsp_t        m_exp;
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_strobes = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (rq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: got rdata %h err %b, expected none", rsp_rdata, rsp_err);
         end else begin
            m_exp = rq.pop_front();
            chk("rsp_rdata", rsp_rdata, m_exp.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_exp.err});
            chk("rsp_cycle", cyc, m_exp.cyc);
         end
      end
   end

   always @(posedge dm_dmwr) begin
      n_strobes++;
      if (wq_din.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_write: got din %h addr %h, expected none", dm_din, dm_address);
      end else begin
         chk("wr_din", dm_din, wq_din.pop_front());
         chk("wr_addr", {22'h0, dm_address}, {22'h0, wq_adr.pop_front()});
      end
      dmem[dm_address] = dm_din;
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input logic [31:0] exp_din);
      int   t;
      rsp_t e;
      t = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         n_chk++;
         $display("FAIL accept_timeout: got req_ready 0, expected 1 within 50 cycles");
         return;
      end
      e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + 1 + lat;
      rq.push_back(e);
      if (we && !exp_err) begin
         wq_din.push_back(exp_din);
         wq_adr.push_back(a[11:2]);
      end
      @(posedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((rq.size() != 0 || wq_din.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", rq.size() + wq_din.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) dmem[i] = i;
      #12;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("rst_dm_address", {22'h0, dm_address}, 32'h0);
      chk("rst_dm_dmwr", {31'h0, dm_dmwr}, 32'h0);
      chk("rst_dm_din", dm_din, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // word load, store, then sub-word loads of the stored word
      issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h00000005, 1'b0, 1, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF);
      issue(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 32'h000000DE, 1'b0, 1, 32'h0);
      issue(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 1, 32'h0);
      issue(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 32'h0000BEEF, 1'b0, 1, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h09, 32'hAAAAAA55, 32'h0, 1'b0, 3, 32'hDEAD55EF);
      issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEAD55EF, 1'b0, 1, 32'h0);
      go_idle();

      // error requests never touch memory
      issue(1'b0, 2'b01, 1'b1, 32'h03, 32'h0, 32'h0, 1'b1, 0, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 32'h0);
      issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 0, 32'h0);
      go_idle();
      drain();

      // req_valid held high across alternating stores and loads
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0, 2, 32'h11111111);
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222, 32'h0, 1'b0, 2, 32'h22222222);
      issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h22222222, 1'b0, 1, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 1'b0, 3, 32'hABCD1111);
      issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000ABCD, 1'b0, 1, 32'h0);
      issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h00000011, 1'b0, 1, 32'h0);
      go_idle();
      drain();

      // reset during WSET of a word store: no strobe, no response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h12345678;
      chk("pre_rst_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("midrst_dm_dmwr", {31'h0, dm_dmwr}, 32'h0);
      chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h00000004, 1'b0, 1, 32'h0);
      go_idle();
      drain();
      repeat (5) @(negedge clk);
      chk("strobe_count", n_strobes, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
